// File: rtl/fas_spectrum_analyzer.sv
// Spectrum analysis stage: scans a 16-bin complex frame for the max-power bin and reports its index.
// Optional macro FAS_ANALYSIS_MAG_OUT_EN adds the max_pw output carrying the winning power.
module fas_spectrum_analyzer #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NBIN = 16,
  parameter int unsigned FW   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fft_valid,
  input  logic [NBIN*2*DW-1:0]   fft_bus,
  output logic                   done,
  output logic [FW-1:0]          freq,
  output logic                   overflow
`ifdef FAS_ANALYSIS_MAG_OUT_EN
  ,
  output logic [2*DW-1:0]        max_pw
`endif
);

  localparam int unsigned BW  = 2*DW;
  localparam int unsigned PW  = 2*DW;
  localparam int unsigned FRW = NBIN*BW;
  localparam int unsigned CW  = FW+1;
  localparam logic [CW-1:0] LAST = CW'(NBIN);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           pend_v_q, pend_v_d;
  logic           load_work, work_from_pend, load_pend, complete, drop;

  logic [FRW-1:0] work_q, pend_q;
  logic [PW-1:0]  pw_q, max_q;
  logic [FW-1:0]  max_idx_q;

  // Stage 1: power of the bin addressed by the counter
  logic [BW-1:0]        bin_w;
  logic signed [DW-1:0] re, im;
  logic signed [PW-1:0] sq_re, sq_im;
  logic [PW-1:0]        pw_c;

  assign bin_w = work_q[BW*cnt_q[FW-1:0] +: BW];
  assign re    = bin_w[BW-1:DW];
  assign im    = bin_w[DW-1:0];
  assign sq_re = PW'(re) * PW'(re);
  assign sq_im = PW'(im) * PW'(im);
  assign pw_c  = $unsigned(sq_re) + $unsigned(sq_im);

  // Stage 2: bin 0 seeds the max, later bins win only when strictly greater
  logic          cmp_v, take;
  logic [FW-1:0] cmp_idx, win_idx;

  assign cmp_v   = (state_q == SCAN) && (cnt_q != '0);
  assign cmp_idx = FW'(cnt_q - CW'(1));
  assign take    = (cnt_q == CW'(1)) || (pw_q > max_q);
  assign win_idx = take ? cmp_idx : max_idx_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pend_v_d       = pend_v_q;
    load_work      = 1'b0;
    work_from_pend = 1'b0;
    load_pend      = 1'b0;
    complete       = 1'b0;
    drop           = 1'b0;
    case (state_q)
      IDLE: begin
        if (fft_valid) begin
          load_work = 1'b1;
          cnt_d     = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          complete = 1'b1;
          cnt_d    = '0;
          if (pend_v_q) begin
            load_work      = 1'b1;
            work_from_pend = 1'b1;
            load_pend      = fft_valid;
            pend_v_d       = fft_valid;
          end else if (fft_valid) begin
            load_work = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (fft_valid) begin
          if (pend_v_q) begin
            drop = 1'b1;
          end else begin
            load_pend = 1'b1;
            pend_v_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_v_q <= 1'b0;
      done     <= 1'b0;
      freq     <= '0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_v_q <= pend_v_d;
      done     <= complete;
      if (complete) freq <= win_idx;
      if (drop) overflow <= 1'b1;
    end
  end

  // Frame storage and pipeline datapath carry no reset
  always_ff @(posedge clk) begin
    if (load_work) work_q <= work_from_pend ? pend_q : fft_bus;
    if (load_pend) pend_q <= fft_bus;
    if (state_q == SCAN) pw_q <= pw_c;
    if (cmp_v && take) begin
      max_q     <= pw_q;
      max_idx_q <= cmp_idx;
    end
  end

`ifdef FAS_ANALYSIS_MAG_OUT_EN
  logic [PW-1:0] win_pw;
  assign win_pw = take ? pw_q : max_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_pw <= '0;
    end else if (complete) begin
      max_pw <= win_pw;
    end
  end
`else
  // Winning power stays internal to the compare stage.
`endif

endmodule

// File: tb/tb_fas_spectrum_analyzer.sv
// Self-checking bench for fas_spectrum_analyzer: frame-level reference model plus directed literal checks.
module tb_fas_spectrum_analyzer;
  localparam int DW   = 16;
  localparam int NBIN = 16;
  localparam int FW   = 4;
  localparam int FRW  = NBIN*2*DW;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           fft_valid = 1'b0;
  logic [FRW-1:0] fft_bus = '0;
  logic           done;
  logic [FW-1:0]  freq;
  logic           overflow;
`ifdef FAS_ANALYSIS_MAG_OUT_EN
  logic [2*DW-1:0] max_pw;
`endif

  fas_spectrum_analyzer #(.DW(DW), .NBIN(NBIN), .FW(FW)) dut (
    .clk      (clk),
    .rst      (rst),
    .fft_valid(fft_valid),
    .fft_bus  (fft_bus),
    .done     (done),
    .freq     (freq),
    .overflow (overflow)
`ifdef FAS_ANALYSIS_MAG_OUT_EN
    ,
    .max_pw   (max_pw)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Power of every bin by plain integer arithmetic; first strictly-greater bin wins
  function automatic void analyse(input logic [FRW-1:0] f, output int idx, output longint pw);
    logic signed [DW-1:0] r, i;
    longint p;
    idx = 0;
    pw  = 0;
    for (int k = 0; k < NBIN; k++) begin
      r = f[2*DW*k+DW +: DW];
      i = f[2*DW*k +: DW];
      p = longint'(r)*longint'(r) + longint'(i)*longint'(i);
      if (k == 0 || p > pw) begin
        idx = k;
        pw  = p;
      end
    end
  endfunction

  function automatic logic [FRW-1:0] put(input logic [FRW-1:0] f, input int k,
                                         input logic [DW-1:0] r, input logic [DW-1:0] i);
    logic [FRW-1:0] g;
    g = f;
    g[2*DW*k +: 2*DW] = {r, i};
    return g;
  endfunction

  function automatic logic [DW-1:0] rand_comp(input int mode);
    logic [DW-1:0] v;
    case (mode)
      0: v = DW'($urandom_range(0, 4) - 2);
      1: v = DW'($urandom);
      2: v = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [FRW-1:0] rand_frame();
    logic [FRW-1:0] f;
    int mode;
    f = '0;
    mode = $urandom_range(0, 3);
    for (int k = 0; k < NBIN; k++) begin
      if ($urandom_range(0, 3) == 0) mode = $urandom_range(0, 3);
      f = put(f, k, rand_comp(mode), rand_comp(mode));
    end
    return f;
  endfunction

  // Frame-level reference: one frame in flight, one waiting, result due 17 edges after start
  bit     m_busy = 0;
  int     m_rem = 0;
  bit     m_pend_v = 0;
  int     m_cur_f = 0, m_pend_f = 0;
  longint m_cur_pw = 0, m_pend_pw = 0;
  bit     exp_done = 0;
  int     exp_freq = 0;
  longint exp_pw = 0;
  bit     exp_ov = 0;

  always @(posedge clk or negedge rst) begin
    int     nf;
    longint npw;
    if (!rst) begin
      m_busy = 0; m_rem = 0; m_pend_v = 0;
      exp_done = 0; exp_freq = 0; exp_pw = 0; exp_ov = 0;
    end else begin
      analyse(fft_bus, nf, npw);
      exp_done = 0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          exp_done = 1;
          exp_freq = m_cur_f;
          exp_pw   = m_cur_pw;
          if (m_pend_v) begin
            m_cur_f = m_pend_f; m_cur_pw = m_pend_pw; m_rem = 17;
            m_pend_v = fft_valid;
            if (fft_valid) begin m_pend_f = nf; m_pend_pw = npw; end
          end else if (fft_valid) begin
            m_cur_f = nf; m_cur_pw = npw; m_rem = 17;
          end else begin
            m_busy = 0;
          end
        end else if (fft_valid) begin
          if (m_pend_v) exp_ov = 1;
          else begin m_pend_f = nf; m_pend_pw = npw; m_pend_v = 1; end
        end
      end else if (fft_valid) begin
        m_busy = 1; m_cur_f = nf; m_cur_pw = npw; m_rem = 17;
      end
    end
  end

  always @(negedge clk) begin
    check("done", done, exp_done);
    check("freq", freq, exp_freq);
    check("overflow", overflow, exp_ov);
`ifdef FAS_ANALYSIS_MAG_OUT_EN
    check("max_pw", max_pw, exp_pw);
`endif
  end

  task automatic send(input logic [FRW-1:0] f);
    @(negedge clk);
    fft_valid = 1'b1;
    fft_bus   = f;
    @(negedge clk);
    fft_valid = 1'b0;
    fft_bus   = rand_frame();
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_dir(input string nm, input logic [FRW-1:0] f, input int lit_f, input longint lit_pw);
    int mf, lat;
    longint mpw;
    analyse(f, mf, mpw);
    check({nm, "_model_freq"}, mf, lit_f);
    check({nm, "_model_pw"}, mpw, lit_pw);
    send(f);
    wait_done(lat);
    check({nm, "_latency"}, lat, 17);
    check({nm, "_freq"}, freq, lit_f);
`ifdef FAS_ANALYSIS_MAG_OUT_EN
    check({nm, "_max_pw"}, max_pw, lit_pw);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FRW-1:0] f, fa, fb, fc;
    int nd, c1, c2, f1, f2;

    repeat (3) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_freq", freq, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b1;

    run_dir("zero", '0, 0, 0);

    f = put('0, 5, 16'h0100, 16'h0000);
    run_dir("bin5", f, 5, 64'h0001_0000);

    f = '0;
    for (int k = 0; k < NBIN; k++) f = put(f, k, 16'h0001, 16'h0000);
    f = put(f, 3, 16'h0040, 16'hFFC0);
    f = put(f, 12, 16'h0040, 16'hFFC0);
    run_dir("tie", f, 3, 8192);

    f = put('0, 9, 16'h8000, 16'h8000);
    f = put(f, 2, 16'h7FFF, 16'h7FFF);
    run_dir("extreme", f, 9, 64'h8000_0000);

    // Back-to-back frames: A starts, B waits, C is dropped
    fa = put('0, 4, 16'h0100, 16'h0000);
    fb = put('0, 11, 16'h0200, 16'h0000);
    fc = put('0, 1, 16'h0300, 16'h0000);
    nd = 0; c1 = -1; c2 = -1; f1 = -1; f2 = -1;
    @(negedge clk);
    for (int c = 0; c < 60; c++) begin
      if (done) begin
        nd++;
        if (nd == 1) begin c1 = c; f1 = int'(freq); end
        if (nd == 2) begin c2 = c; f2 = int'(freq); end
      end
      fft_valid = (c == 0 || c == 5 || c == 8);
      fft_bus   = (c == 0) ? fa : (c == 5) ? fb : (c == 8) ? fc : rand_frame();
      @(negedge clk);
    end
    check("burst_ndone", nd, 2);
    check("burst_t1", c1, 18);
    check("burst_f1", f1, 4);
    check("burst_t2", c2, 35);
    check("burst_f2", f2, 11);
    check("burst_overflow", overflow, 1);

    // Reset in the middle of a scan
    f = put('0, 7, 16'h0010, 16'h0020);
    send(fa);
    repeat (7) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_done", done, 0);
    check("abort_freq", freq, 0);
    check("abort_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_dir("after_rst", f, 7, 1280);

    // Random traffic against the reference model
    repeat (500) begin
      @(negedge clk);
      fft_valid = ($urandom_range(0, 5) == 0);
      fft_bus   = rand_frame();
    end
    @(negedge clk);
    fft_valid = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
